// File: rtl/mem_access_pkg.sv
// Shared encodings and byte-lane helpers for the RAM access front end.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    SRC_FETCH = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  // Size 2'b11 falls through to full-word lanes.
  function automatic logic [3:0] write_en_lookup(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 4'b0001 << off;
      SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return off[0];
      default:   return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half/word out of a RAM word and sign- or zero-extends it.
module mem_load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic [1:0]            off,
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  output logic [DATA_WIDTH-1:0] rdata
);

  function automatic logic [DATA_WIDTH-1:0] extend_byte(input logic signed [7:0] v, input logic uns);
    return uns ? DATA_WIDTH'($unsigned(v)) : DATA_WIDTH'(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend_half(input logic signed [15:0] v, input logic uns);
    return uns ? DATA_WIDTH'($unsigned(v)) : DATA_WIDTH'(v);
  endfunction

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = ram_dout[8*off +: 8];
    half_sel = ram_dout[16*off[1] +: 16];
    case (size)
      SIZE_BYTE: rdata = extend_byte(byte_sel, is_unsigned);
      SIZE_HALF: rdata = extend_half(half_sel, is_unsigned);
      default:   rdata = ram_dout;
    endcase
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Single-port RAM front end: arbitrates fetch vs load/store, aligns stores,
// and returns aligned load data one cycle after grant.
module ram_access_arbiter
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifetch_req,
  input  logic [ADDR_WIDTH+1:0] ifetch_addr,
  output logic                  ifetch_ack,
  output logic                  ifetch_rvalid,
  output logic [DATA_WIDTH-1:0] ifetch_rdata,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic                  data_unsigned,
  input  logic [ADDR_WIDTH+1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ack,
  output logic                  data_rvalid,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  data_misaligned,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [3:0]            ram_write_en,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  src_e       last_contend;
  logic       grant_data_p0;
  logic       grant_fetch_p0;
  logic       both_req_p0;
  logic       mis_p0;
  logic [1:0] off_p0;

  logic       rd_vld_p1;
  src_e       src_p1;
  logic [1:0] off_p1;
  logic [1:0] size_p1;
  logic       uns_p1;
  logic       mis_vld_p1;
  logic [DATA_WIDTH-1:0] load_aligned_p1;

  logic [1:0] unused_ifetch_off;
  assign unused_ifetch_off = ifetch_addr[1:0];

  // ---- p0: arbitration and RAM request in the grant cycle ----
  always_comb begin
    off_p0         = data_addr[1:0];
    mis_p0         = is_misaligned(data_size, off_p0);
    both_req_p0    = ifetch_req && data_req;
    grant_data_p0  = reset_n && data_req && (!ifetch_req || last_contend == SRC_FETCH);
    grant_fetch_p0 = reset_n && ifetch_req && !grant_data_p0;
  end

  assign ifetch_ack   = grant_fetch_p0;
  assign data_ack     = grant_data_p0;
  assign ram_addr     = grant_data_p0 ? data_addr[ADDR_WIDTH+1:2] : ifetch_addr[ADDR_WIDTH+1:2];
  assign ram_din      = store_data(data_size, data_wdata);
  assign ram_write_en = (grant_data_p0 && data_we && !mis_p0)
                        ? write_en_lookup(data_size, off_p0) : 4'b0000;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_contend <= SRC_FETCH;
      rd_vld_p1    <= 1'b0;
      src_p1       <= SRC_FETCH;
      off_p1       <= 2'b00;
      size_p1      <= SIZE_BYTE;
      uns_p1       <= 1'b0;
      mis_vld_p1   <= 1'b0;
    end else begin
      if (both_req_p0) last_contend <= grant_data_p0 ? SRC_DATA : SRC_FETCH;
      rd_vld_p1  <= grant_fetch_p0 || (grant_data_p0 && !data_we && !mis_p0);
      mis_vld_p1 <= grant_data_p0 && mis_p0;
      if (grant_fetch_p0 || grant_data_p0) begin
        src_p1  <= grant_data_p0 ? SRC_DATA : SRC_FETCH;
        off_p1  <= off_p0;
        size_p1 <= data_size;
        uns_p1  <= data_unsigned;
      end
    end
  end

  // ---- p1: read return, aligned from the RAM output ----
  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .ram_dout    (ram_dout),
    .off         (off_p1),
    .size        (size_p1),
    .is_unsigned (uns_p1),
    .rdata       (load_aligned_p1)
  );

  assign ifetch_rvalid   = rd_vld_p1 && (src_p1 == SRC_FETCH);
  assign data_rvalid     = rd_vld_p1 && (src_p1 == SRC_DATA);
  assign ifetch_rdata    = ifetch_rvalid ? ram_dout : '0;
  assign data_rdata      = data_rvalid ? load_aligned_p1 : '0;
  assign data_misaligned = mis_vld_p1;

endmodule
